hazard_scoreboard: RTL

- Parametrised scoreboard-based hazard detector for the ARM pipeline's ID stage.
- Tracks in-flight register writes with per-register counters instead of comparing sources against fixed EXE/MEM destinations, so pipeline depth is free.
- Supports N source operands and a runtime forwarding mode; in forwarding mode only load-use hazards stall.
- Keeps a saturating stall-cycle performance counter and a sticky underflow error flag.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/sb_counter.sv | 53 +++++
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared defaults, register index type and counter limit for
//               the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_REG_W    = 4;
  localparam int DEF_CNT_W    = 2;
  localparam int CNT_MAX      = 2**DEF_CNT_W - 1;

  typedef logic [DEF_REG_W-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/sb_counter.sv
// ============================================================================
// Module      : sb_counter
// Description : One outstanding-write counter with same-cycle effective value
//               and an underflow strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] eff_out,
  output logic             nz_nxt,
  output logic             underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dec_ok;

  // A counter already at zero absorbs the decrement and flags it instead.
  assign w_dec_ok  = dec & (r_cnt != '0);
  assign underflow = dec & (r_cnt == '0);
  assign eff_out   = w_dec_ok ? (r_cnt - CNT_W'(1)) : r_cnt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (inc && !w_dec_ok) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (!inc && w_dec_ok) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  assign nz_nxt = |w_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage hazard detector tracking in-flight register writes
//               with per-register counters; optional load-use-only mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int REG_W       = DEF_REG_W,
  parameter int NUM_SRC     = 3,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_en,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     id_wb_en,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic                     wb_wb_en,
  input  logic [REG_W-1:0]         wb_dest,
  input  logic                     wb_is_load,
  output logic                     hazard_detected,
  output logic                     busy,
  output logic [STALL_CNT_W-1:0]   stall_cycles,
  output logic                     underflow_err
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic                   w_wb_fire;
  logic                   w_issue;
  logic [NUM_SRC-1:0]     w_src_haz;
  logic                   w_sat_haz;
  logic [NUM_REGS-1:0]    w_pend_inc;
  logic [NUM_REGS-1:0]    w_pend_dec;
  logic [NUM_REGS-1:0]    w_load_inc;
  logic [NUM_REGS-1:0]    w_load_dec;
  logic [NUM_REGS-1:0]    w_pend_nz;
  logic [NUM_REGS-1:0]    w_load_nz;
  logic [NUM_REGS-1:0]    w_pend_uf;
  logic [NUM_REGS-1:0]    w_load_uf;
  logic [CNT_W-1:0]       w_eff_pend [NUM_REGS];
  logic [CNT_W-1:0]       w_eff_load [NUM_REGS];

  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   r_underflow_err;
  logic                   r_busy;

  assign w_wb_fire = wb_valid & wb_wb_en;

  // Only indices below NUM_REGS get a counter, so out-of-range ones never match.
  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
      assign w_pend_inc[r] = w_issue & (id_dest == REG_W'(r));
      assign w_load_inc[r] = w_issue & id_is_load & (id_dest == REG_W'(r));
      assign w_pend_dec[r] = w_wb_fire & (wb_dest == REG_W'(r));
      assign w_load_dec[r] = w_wb_fire & wb_is_load & (wb_dest == REG_W'(r));

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_pend (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_pend_inc[r]),
        .dec       (w_pend_dec[r]),
        .eff_out   (w_eff_pend[r]),
        .nz_nxt    (w_pend_nz[r]),
        .underflow (w_pend_uf[r])
      );

      sb_counter #(
        .CNT_W (CNT_W)
      ) u_load (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_load_inc[r]),
        .dec       (w_load_dec[r]),
        .eff_out   (w_eff_load[r]),
        .nz_nxt    (w_load_nz[r]),
        .underflow (w_load_uf[r])
      );
    end
  endgenerate

  always_comb begin
    w_src_haz = '0;
    w_sat_haz = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (id_src[k*REG_W +: REG_W] == REG_W'(r)) begin
          w_src_haz[k] = id_src_used[k] &
                         (fwd_en ? (w_eff_load[r] != '0) : (w_eff_pend[r] != '0));
        end
      end
    end
    // A full destination counter cannot take another outstanding write.
    for (int r = 0; r < NUM_REGS; r++) begin
      if (id_dest == REG_W'(r)) begin
        w_sat_haz = id_wb_en & (w_eff_pend[r] == c_cnt_max);
      end
    end
  end

  assign hazard_detected = id_valid & ~flush & ((|w_src_haz) | w_sat_haz);
  assign w_issue         = id_valid & ~flush & ~hazard_detected & id_wb_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles  <= '0;
      r_underflow_err <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      if (hazard_detected && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
      if ((|w_pend_uf) || (|w_load_uf)) begin
        r_underflow_err <= 1'b1;
      end
      r_busy <= (|w_pend_nz) | (|w_load_nz);
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign underflow_err = r_underflow_err;
  assign busy          = r_busy;

endmodule

`default_nettype wire
